// File: rtl/distance_sensor_frontend.sv
// Ultrasonic ranging front end: fires a periodic trigger, times the echo pulse and publishes
// the distance in cm. Any sensor timeout publishes 0 so the consumer treats the car as too close.
module distance_sensor_frontend #(
  parameter int unsigned TRIG_CYCLES    = 10,
  parameter int unsigned TICKS_PER_CM   = 58,
  parameter int unsigned TIMEOUT_CYCLES = 25000,
  parameter int unsigned PERIOD_CYCLES  = 60000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       echo,
  output logic       trig,
  output logic [6:0] leading_distance,
  output logic       dist_valid,
  output logic       timeout_err
);

  localparam int unsigned PW = $clog2(PERIOD_CYCLES);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned KW = (TICKS_PER_CM > 1) ? $clog2(TICKS_PER_CM) : 1;

  localparam logic [PW-1:0] PeriodLast  = PW'(PERIOD_CYCLES - 1);
  localparam logic [PW-1:0] TrigLast    = PW'(TRIG_CYCLES - 1);
  localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [KW-1:0] TickLast    = KW'(TICKS_PER_CM - 1);
  localparam logic [6:0]    CmMax       = 7'd127;

  typedef enum logic [2:0] {
    StIdle,
    StTrig,
    StWaitEcho,
    StMeasure,
    StHold
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] period_q, period_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [KW-1:0] tick_q, tick_d;
  logic [6:0]    cm_q, cm_d;
  logic [6:0]    dist_q, dist_d;
  logic          valid_q, valid_d;
  logic          terr_q, terr_d;

  logic          echo_m, echo_s, echo_s_prev;
  logic          echo_rise, echo_fall;
  logic [KW-1:0] tick_adv;
  logic [6:0]    cm_adv;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      echo_m      <= 1'b0;
      echo_s      <= 1'b0;
      echo_s_prev <= 1'b0;
    end else begin
      echo_m      <= echo;
      echo_s      <= echo_m;
      echo_s_prev <= echo_s;
    end
  end

  assign echo_rise = echo_s & ~echo_s_prev;
  assign echo_fall = ~echo_s & echo_s_prev;

  // Counting is done on echo_s_prev so the edge cycle that entered MEASURE and the last
  // high cycle seen at the falling edge are both included: exactly N ticks for N high cycles.
  always_comb begin
    tick_adv = tick_q + KW'(1);
    cm_adv   = cm_q;
    if (tick_q == TickLast) begin
      tick_adv = '0;
      cm_adv   = (cm_q == CmMax) ? cm_q : cm_q + 7'd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    period_d = (state_q == StIdle) ? period_q : period_q + PW'(1);
    timer_d  = timer_q;
    tick_d   = tick_q;
    cm_d     = cm_q;
    dist_d   = dist_q;
    valid_d  = 1'b0;
    terr_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d  = StTrig;
          period_d = '0;
        end
      end
      StTrig: begin
        if (period_q == TrigLast) begin
          state_d = StWaitEcho;
          timer_d = '0;
        end
      end
      StWaitEcho: begin
        if (echo_rise) begin
          state_d = StMeasure;
          cm_d    = '0;
          tick_d  = '0;
          timer_d = TW'(1);  // the edge cycle is already the first high cycle
        end else if (timer_q == TimeoutLast) begin
          state_d = StHold;
          dist_d  = '0;
          valid_d = 1'b1;
          terr_d  = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StMeasure: begin
        if (echo_fall) begin
          state_d = StHold;
          dist_d  = cm_adv;
          valid_d = 1'b1;
        end else if (timer_q == TimeoutLast) begin
          state_d = StHold;
          dist_d  = '0;
          valid_d = 1'b1;
          terr_d  = 1'b1;
        end else begin
          tick_d  = tick_adv;
          cm_d    = cm_adv;
          timer_d = timer_q + TW'(1);
        end
      end
      StHold: begin
        if (period_q == PeriodLast) begin
          state_d  = enable ? StTrig : StIdle;
          period_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      period_q <= '0;
      timer_q  <= '0;
      tick_q   <= '0;
      cm_q     <= '0;
      dist_q   <= '0;
      valid_q  <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      timer_q  <= timer_d;
      tick_q   <= tick_d;
      cm_q     <= cm_d;
      dist_q   <= dist_d;
      valid_q  <= valid_d;
      terr_q   <= terr_d;
    end
  end

  assign trig             = (state_q == StTrig);
  assign leading_distance = dist_q;
  assign dist_valid       = valid_q;
  assign timeout_err      = terr_q;

endmodule

// File: tb/tb_distance_sensor_frontend.sv
// Directed + randomized bench for distance_sensor_frontend with small timing parameters.
module tb_distance_sensor_frontend;

  localparam int unsigned TrigCycles    = 3;
  localparam int unsigned TicksPerCm    = 4;
  localparam int unsigned TimeoutCycles = 600;
  localparam int unsigned PeriodCycles  = 1500;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       echo = 1'b0;
  logic       trig;
  logic [6:0] leading_distance;
  logic       dist_valid;
  logic       timeout_err;

  distance_sensor_frontend #(
    .TRIG_CYCLES   (TrigCycles),
    .TICKS_PER_CM  (TicksPerCm),
    .TIMEOUT_CYCLES(TimeoutCycles),
    .PERIOD_CYCLES (PeriodCycles)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .echo            (echo),
    .trig            (trig),
    .leading_distance(leading_distance),
    .dist_valid      (dist_valid),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  int cyc_n = 0;
  int trig_rise = -1, trig_rise_prev = -1, trig_fall = -1;
  int trig_run = 0, trig_len = 0;
  int n_rises = 0, n_valid = 0, valid_at = -1;
  logic prev_trig = 1'b0, prev_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  // Reference: floor of high cycles over ticks-per-cm, clamped to the 7-bit range.
  function automatic int ref_cm(input int n_high);
    int cm;
    cm = n_high / TicksPerCm;
    return (cm > 127) ? 127 : cm;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
    if (trig && !prev_trig) begin
      trig_rise_prev = trig_rise;
      trig_rise      = cyc_n;
      trig_run       = 0;
      n_rises++;
    end
    if (trig) trig_run++;
    if (!trig && prev_trig) begin
      trig_fall = cyc_n;
      trig_len  = trig_run;
    end
    if (dist_valid) begin
      check("valid_single_cycle", prev_valid, 0);
      n_valid++;
      valid_at = cyc_n;
    end
    if (timeout_err) check("terr_with_valid", dist_valid, 1);
    prev_trig  = trig;
    prev_valid = dist_valid;
  endtask

  // kind: 0 = trig rise, 1 = trig fall, 2 = dist_valid
  task automatic wait_ev(input int kind, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      cyc();
      case (kind)
        0: ok = (trig_rise == cyc_n);
        1: ok = (trig_fall == cyc_n);
        default: ok = dist_valid;
      endcase
    end
  endtask

  task automatic start_period(input bit chk_period, output bit ok);
    wait_ev(0, 2 * PeriodCycles, ok);
    check("trig_rise_seen", ok, 1);
    if (!ok) return;
    if (chk_period) check("trig_period", trig_rise - trig_rise_prev, PeriodCycles);
    wait_ev(1, 20, ok);
    check("trig_fall_seen", ok, 1);
    if (ok) check("trig_width", trig_len, TrigCycles);
  endtask

  task automatic run_meas(input string tag, input int n_high, input bit chk_period);
    bit ok;
    start_period(chk_period, ok);
    if (!ok) return;
    repeat ($urandom_range(2, 40)) cyc();
    echo = 1'b1;
    repeat (n_high) cyc();
    echo = 1'b0;
    wait_ev(2, 50, ok);
    check({tag, "_valid_seen"}, ok, 1);
    if (ok) begin
      check({tag, "_dist"}, leading_distance, ref_cm(n_high));
      check({tag, "_terr"}, timeout_err, 0);
    end
  endtask

  initial begin
    bit ok;
    int nv, nr, echo_at;

    // Reset held with echo toggling
    for (int i = 0; i < 20; i++) begin
      echo = ~echo;
      cyc();
      check("reset_outputs", {trig, dist_valid, timeout_err, leading_distance}, 0);
    end
    echo = 1'b0;
    rst  = 1'b1;
    for (int i = 0; i < 50; i++) begin
      echo = ($urandom_range(0, 1) == 1);
      cyc();
    end
    echo = 1'b0;
    check("no_trig_while_disabled", n_rises, 0);
    check("no_publish_after_reset", n_valid, 0);

    // Nominal, floor, saturation
    enable = 1'b1;
    run_meas("nominal", 120, 1'b0);
    run_meas("floor", 201, 1'b1);
    run_meas("saturate", 560, 1'b1);
    run_meas("nominal2", 120, 1'b1);

    // No echo: fault 600 cycles after entering WAIT_ECHO
    start_period(1'b1, ok);
    check("hold_before_fault", leading_distance, 30);
    wait_ev(2, 700, ok);
    check("noecho_valid_seen", ok, 1);
    check("noecho_latency", valid_at - trig_fall, TimeoutCycles);
    check("noecho_dist", leading_distance, 0);
    check("noecho_terr", timeout_err, 1);

    // Stuck echo: 2-flop sync plus 600 high cycles
    start_period(1'b1, ok);
    repeat (5) cyc();
    echo    = 1'b1;
    echo_at = cyc_n;
    wait_ev(2, 700, ok);
    echo = 1'b0;
    check("stuck_valid_seen", ok, 1);
    check("stuck_latency", valid_at - echo_at, TimeoutCycles + 2);
    check("stuck_dist", leading_distance, 0);
    check("stuck_terr", timeout_err, 1);
    run_meas("after_stuck", 200, 1'b1);

    for (int k = 0; k < 4; k++) run_meas("random", $urandom_range(1, 590), 1'b1);

    // Enable drop mid-measure
    start_period(1'b1, ok);
    repeat (10) cyc();
    echo = 1'b1;
    repeat (40) cyc();
    enable = 1'b0;
    repeat (40) cyc();
    echo = 1'b0;
    wait_ev(2, 50, ok);
    check("drop_valid_seen", ok, 1);
    check("drop_dist", leading_distance, 20);
    wait_ev(0, 2 * PeriodCycles, ok);
    check("drop_no_more_trig", ok, 0);
    enable = 1'b1;
    wait_ev(0, 5, ok);
    check("reenable_trig", ok, 1);

    // Reset mid-MEASURE
    wait_ev(1, 20, ok);
    repeat (8) cyc();
    echo = 1'b1;
    repeat (50) cyc();
    rst = 1'b0;
    #1;
    check("midreset_outputs", {trig, dist_valid, timeout_err, leading_distance}, 0);
    echo   = 1'b0;
    enable = 1'b0;
    nv = n_valid;
    nr = n_rises;
    repeat (3) cyc();
    rst = 1'b1;
    repeat (100) cyc();
    check("midreset_no_publish", n_valid - nv, 0);
    check("midreset_no_trig", n_rises - nr, 0);
    check("midreset_dist_zero", leading_distance, 0);

    enable = 1'b1;
    run_meas("recover", $urandom_range(1, 590), 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/distance_sensor_frontend.md
Name: distance_sensor_frontend

Overview:
- Upstream ranging stage for the self-driving-car control unit. It fires an ultrasonic sensor periodically and measures the echo pulse width.
- Converts the width to centimetres and publishes the 7-bit leading_distance consumed by the car control FSM.
- On any sensor fault it reports the conservative value 0, so downstream treats the car as too close and stops.

Parameters:
TRIG_CYCLES, 10, trigger pulse width in clk cycles
TICKS_PER_CM, 58, echo-high clk cycles per centimetre (1 MHz clk)
TIMEOUT_CYCLES, 25000, maximum cycles allowed in WAIT_ECHO and in MEASURE
PERIOD_CYCLES, 60000, cycles from TRIG entry to the next TRIG entry; must be > TRIG_CYCLES + 2*TIMEOUT_CYCLES + 4

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low
enable  input  1  start/continue periodic ranging
echo  input  1  sensor echo, asynchronous; double-flop synchronised internally
trig  output  1  sensor trigger pulse
leading_distance  output  7  last measured distance in cm, 0..127
dist_valid  output  1  one-cycle pulse when leading_distance updates
timeout_err  output  1  one-cycle pulse on echo timeout, coincident with dist_valid

Behaviour:
- Reset (rst=0, async): state=IDLE, trig=0, leading_distance=0, dist_valid=0, timeout_err=0, all counters cleared.
  - Reset mid-operation aborts the measurement.
  - No publish happens on reset release.
- echo synchronised through 2 flops to echo_s. Edges are detected on echo_s against its previous value.
- States: IDLE, TRIG, WAIT_ECHO, MEASURE, HOLD.
- IDLE: trig=0. When enable=1, next state is TRIG and the period counter is cleared to 0.
- TRIG: trig=1 for exactly TRIG_CYCLES cycles, then WAIT_ECHO.
- WAIT_ECHO: trig=0, wait counter counts up.
  - echo_s rising edge -> MEASURE, cm=0, tick=0.
  - Wait counter reaching TIMEOUT_CYCLES -> publish fault, then HOLD.
- MEASURE: counts every cycle in which echo_s=1.
  - tick counts 0..TICKS_PER_CM-1; on wrap, cm increments, saturating at 127 (no wrap).
  - echo_s falling edge -> next cycle leading_distance=cm and dist_valid=1 for one cycle, then HOLD.
  - Published value = min(127, floor(N/TICKS_PER_CM)), where N = cycles echo_s was high.
  - echo_s high for TIMEOUT_CYCLES -> publish fault, then HOLD.
- Fault publish: leading_distance=0, dist_valid=1 and timeout_err=1 for the same single cycle.
- HOLD: waits until the period counter = PERIOD_CYCLES-1.
  - Then TRIG if enable=1 (period counter reset), otherwise IDLE.
- enable deasserted mid-cycle: the current measurement completes and publishes; the block then goes IDLE at the period end.
- echo high while in TRIG or HOLD: ignored. A rising edge only counts in WAIT_ECHO.
- leading_distance holds its value between publishes. dist_valid and timeout_err are never high for more than 1 cycle.
- Period counter width: clog2(PERIOD_CYCLES). It runs in every state except IDLE.

Test Plan:
All scenarios use TRIG_CYCLES=3, TICKS_PER_CM=4, TIMEOUT_CYCLES=600, PERIOD_CYCLES=1500.
1. Reset behaviour:
   - Stimulus: hold rst=0 for 20 cycles with echo toggling, then release.
   - Response: trig, dist_valid, timeout_err and leading_distance all remain 0; no trig until enable=1.
   - Assert rst=0 mid-MEASURE: outputs go to 0 immediately and no dist_valid follows.
2. Nominal measurement:
   - Stimulus: enable=1; echo high 120 cycles after trig.
   - Response: trig high exactly 3 cycles; leading_distance=30; a single dist_valid pulse; timeout_err=0.
   - Next trig occurs 1500 cycles after the previous trig rise.
3. Floor and saturation:
   - Stimulus: echo high 201 cycles, then echo high 560 cycles.
   - Response: leading_distance=50 after the first, 127 after the second (saturated, not 140-128=12).
4. No echo:
   - Stimulus: echo held 0.
   - Response: 600 cycles after entering WAIT_ECHO, dist_valid=1 and timeout_err=1 in the same cycle; leading_distance=0 (previously 30).
5. Stuck echo:
   - Stimulus: echo rises and stays high.
   - Response: after 600 high cycles, fault publish with leading_distance=0 and timeout_err pulse; the next period triggers normally.
6. Enable drop:
   - Stimulus: drop enable during MEASURE (echo 80 cycles total).
   - Response: leading_distance=20 is published; block goes IDLE at the period end; no further trig until enable=1.
